// File: rtl/sram_wbuf_arb_pkg.sv
// rtl/sram_wbuf_arb_pkg.sv - shared config: RAM parameter defaults, data/byte widths, write-buffer entry layout
package sram_wbuf_arb_pkg;

    localparam int DEF_P_DW       = 6;
    localparam int DEF_AW         = 6;
    localparam int DEF_WB_DEPTH_P = 2;

    function automatic int dw_of(input int p_dw);
        return 1 << p_dw;
    endfunction

    function automatic int bw_of(input int p_dw);
        return (1 << p_dw) / 8;
    endfunction

    // Entry layout, LSB first: data [DW-1:0], be [DW +: BW], addr [DW+BW +: AW]
    function automatic int ent_width(input int aw, input int p_dw);
        return aw + bw_of(p_dw) + dw_of(p_dw);
    endfunction

endpackage

// File: rtl/wbuf_fwd_merge.sv
// rtl/wbuf_fwd_merge.sv - per-byte newest-match merge of buffered writes against a read address
module wbuf_fwd_merge
    import sram_wbuf_arb_pkg::*;
#(
    parameter int P_DW    = DEF_P_DW,
    parameter int AW      = DEF_AW,
    parameter int DEPTH_P = DEF_WB_DEPTH_P
) (
    input  logic [DEPTH_P-1:0]                         head,
    input  logic [DEPTH_P:0]                           count,
    input  logic [AW-1:0]                              rd_addr,
    input  logic [(1<<DEPTH_P)-1:0][AW-1:0]            ent_addr,
    input  logic [(1<<DEPTH_P)-1:0][bw_of(P_DW)-1:0]   ent_be,
    input  logic [(1<<DEPTH_P)-1:0][dw_of(P_DW)-1:0]   ent_data,
    output logic [bw_of(P_DW)-1:0]                     mask,
    output logic [dw_of(P_DW)-1:0]                     data,
    output logic                                       hit
);
    localparam int N  = 1 << DEPTH_P;
    localparam int BW = bw_of(P_DW);

    logic [DEPTH_P-1:0] idx;

    // Walk oldest to newest so a later match overwrites an earlier one per byte.
    always_comb begin
        mask = '0;
        data = '0;
        hit  = 1'b0;
        idx  = head;
        for (int k = 0; k < N; k++) begin
            idx = head + DEPTH_P'(k);
            if ((DEPTH_P+1)'(k) < count && ent_addr[idx] == rd_addr) begin
                hit = 1'b1;
                for (int b = 0; b < BW; b++) begin
                    if (ent_be[idx][b]) begin
                        mask[b]         = 1'b1;
                        data[b*8 +: 8]  = ent_data[idx][b*8 +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/sram_wbuf_arb.sv
// rtl/sram_wbuf_arb.sv - read/write front-end with posted write buffer for a single-port SRAM
// NCPU_WBUF_FWD_EN selects byte-merge forwarding; otherwise reads that hit the buffer stall.
module sram_wbuf_arb
    import sram_wbuf_arb_pkg::*;
#(
    parameter int P_DW       = DEF_P_DW,
    parameter int AW         = DEF_AW,
    parameter int WB_DEPTH_P = DEF_WB_DEPTH_P
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     RD_VALID,
    output logic                     RD_READY,
    input  logic [AW-1:0]            RD_ADDR,
    output logic                     RD_RVALID,
    output logic [dw_of(P_DW)-1:0]   RD_RDATA,
    input  logic                     WR_VALID,
    output logic                     WR_READY,
    input  logic [AW-1:0]            WR_ADDR,
    input  logic [bw_of(P_DW)-1:0]   WR_WE,
    input  logic [dw_of(P_DW)-1:0]   WR_DIN,
    output logic                     WB_EMPTY,
    output logic [AW-1:0]            RAM_ADDR,
    output logic                     RAM_RE,
    output logic [bw_of(P_DW)-1:0]   RAM_WE,
    output logic [dw_of(P_DW)-1:0]   RAM_DIN,
    input  logic [dw_of(P_DW)-1:0]   RAM_DOUT
);
    localparam int DW = dw_of(P_DW);
    localparam int BW = bw_of(P_DW);
    localparam int EW = ent_width(AW, P_DW);
    localparam int N  = 1 << WB_DEPTH_P;

    logic [N-1:0][EW-1:0]   ent_q;
    logic [N-1:0][AW-1:0]   ent_addr;
    logic [N-1:0][BW-1:0]   ent_be;
    logic [N-1:0][DW-1:0]   ent_data;
    logic [WB_DEPTH_P-1:0]  head_q, tail_q;
    logic [WB_DEPTH_P:0]    count_q;
    logic                   rvalid_q;
    logic [BW-1:0]          fwd_mask_q, fwd_mask;
    logic [DW-1:0]          fwd_data_q, fwd_data;
    logic                   fwd_hit, full, empty, blocked, rd_issue, drain, push;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            ent_data[i] = ent_q[i][DW-1:0];
            ent_be[i]   = ent_q[i][DW +: BW];
            ent_addr[i] = ent_q[i][DW+BW +: AW];
        end
    end

    wbuf_fwd_merge #(.P_DW(P_DW), .AW(AW), .DEPTH_P(WB_DEPTH_P)) u_merge (
        .head     (head_q),
        .count    (count_q),
        .rd_addr  (RD_ADDR),
        .ent_addr (ent_addr),
        .ent_be   (ent_be),
        .ent_data (ent_data),
        .mask     (fwd_mask),
        .data     (fwd_data),
        .hit      (fwd_hit)
    );

    assign full  = (count_q == (WB_DEPTH_P+1)'(N));
    assign empty = (count_q == '0);
`ifdef NCPU_WBUF_FWD_EN
    assign blocked = 1'b0;
`else
    assign blocked = fwd_hit;
`endif

    // A full buffer always wins the port; otherwise reads go first and writes fill idle cycles.
    assign RD_READY = !full && !blocked;
    assign rd_issue = RD_VALID && RD_READY;
    assign drain    = !empty && !rd_issue;
    assign WR_READY = !full;
    assign push     = WR_VALID && !full && (|WR_WE);
    assign WB_EMPTY = empty;

    assign RAM_RE   = rd_issue;
    assign RAM_WE   = drain ? ent_be[head_q] : '0;
    assign RAM_ADDR = rd_issue ? RD_ADDR : ent_addr[head_q];
    assign RAM_DIN  = ent_data[head_q];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            rvalid_q   <= 1'b0;
            fwd_mask_q <= '0;
        end else begin
            if (push)  tail_q <= tail_q + 1'b1;
            if (drain) head_q <= head_q + 1'b1;
            count_q    <= count_q + (WB_DEPTH_P+1)'(push) - (WB_DEPTH_P+1)'(drain);
            rvalid_q   <= rd_issue;
            // In stall mode an issued read never hits, so this stays zero there.
            fwd_mask_q <= rd_issue ? fwd_mask : '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (push)     ent_q[tail_q] <= {WR_ADDR, WR_WE, WR_DIN};
        if (rd_issue) fwd_data_q    <= fwd_data;
    end

    assign RD_RVALID = rvalid_q;

    always_comb begin
        RD_RDATA = RAM_DOUT;
        for (int b = 0; b < BW; b++) begin
            if (fwd_mask_q[b]) RD_RDATA[b*8 +: 8] = fwd_data_q[b*8 +: 8];
        end
    end

endmodule

// File: doc/sram_wbuf_arb.md
# sram_wbuf_arb

Upstream front-end for the single-port byte-enable SRAM macro wrapper. Accepts independent read and write request streams, posts writes into a small in-order write buffer, and arbitrates the single RAM port. Reads take priority, and writes drain in idle cycles. Read data reflects every earlier-accepted write, either by byte-merge forwarding or by stalling.

## Interface
Parameters:
- P_DW, default 6: log2 of the data width in bits (64-bit data).
- AW, default 6: RAM word address width.
- WB_DEPTH_P, default 2: log2 of the write-buffer depth (4 entries).

Ports (DW = 1<<P_DW, BW = DW/8):
- CLK, in, 1: the only clock; all state is on the rising edge.
- RST_N, in, 1: reset, asynchronous and active-low.
- RD_VALID / RD_READY, in / out, 1 each: read request handshake.
- RD_ADDR, in, AW: read word address.
- RD_RVALID, out, 1: read response valid, one cycle, no backpressure.
- RD_RDATA, out, DW: read response data.
- WR_VALID / WR_READY, in / out, 1 each: write request handshake.
- WR_ADDR, in, AW: write word address.
- WR_WE, in, BW: byte write mask.
- WR_DIN, in, DW: write data.
- WB_EMPTY, out, 1: write buffer holds no entries.
- RAM_ADDR, out, AW: to RAM ADDR.
- RAM_RE, out, 1: to RAM RE.
- RAM_WE, out, BW: to RAM WE.
- RAM_DIN, out, DW: to RAM DIN.
- RAM_DOUT, in, DW: from RAM DOUT; valid the cycle after RE.

## Operation
- Write buffer: a circular FIFO of {addr, be, data}. Head/tail pointers are WB_DEPTH_P bits; the count is WB_DEPTH_P+1 bits.
  - WR_READY = !full, derived from registered count only.
  - A write handshake with WR_WE == 0 is accepted and discarded.
- Per-cycle arbitration, at most one RAM operation, first match wins:
  1. Full: drain the head (RAM_WE = head.be, RAM_ADDR = head.addr, RAM_DIN = head.data). RD_READY = 0.
  2. RD_VALID and the read is not blocked: issue the read (RAM_RE = 1, RAM_ADDR = RD_ADDR). RD_READY = 1.
  3. Buffer non-empty: drain the head.
  4. Otherwise the RAM is idle: RAM_RE = 0, RAM_WE = 0, and RAM_ADDR/RAM_DIN are don't-care.
- Ordering:
  - A read sees all writes accepted in strictly earlier cycles.
  - A write accepted in the same cycle as a read is ordered after that read.
  - Push and drain in the same cycle are allowed, and count is unchanged.
- Read response:
  - RD_RVALID is asserted exactly one cycle after the read issue.
  - RD_RDATA per byte = fwd_mask ? fwd_data : RAM_DOUT. fwd_mask and fwd_data are registered at issue.
- RD_READY depends combinationally on RD_ADDR (hit detection) and count. RD_READY never depends on WR_VALID.

## Timing
- Reset values: RD_RVALID = 0, RAM_RE = 0, RAM_WE = 0, WB_EMPTY = 1, WR_READY = 1. Pointers, count and fwd_mask are cleared.
- Reset asserted mid-operation discards buffered writes and any pending response, and RD_RVALID drops immediately. RAM contents are not protected.
- Read latency: 1 cycle (issue at t, RD_RVALID at t+1). Back-to-back reads are sustained at 1 per cycle while the buffer is not full.
- Write posting latency: accepted at t, earliest RAM write at t+1.
- Pointer wrap-around is modulo depth. Full is count == 1<<WB_DEPTH_P; empty is count == 0.

## Configuration
- NCPU_WBUF_FWD_EN defined (forwarding):
  - For each byte lane, the newest buffered entry with a matching addr and a set be bit supplies the byte and sets fwd_mask.
  - The search runs over all valid entries from head to tail.
  - Reads are never blocked by a hit.
- NCPU_WBUF_FWD_EN undefined (stalling):
  - A read whose RD_ADDR matches any valid entry is blocked, and RD_READY = 0.
  - The buffer drains until no entry matches.
  - fwd_mask is always 0.

## Structure
- The DW/BW derivations and the entry field layout belong in the shared config header, beside the existing RAM parameters.
- One sub-module, wbuf_fwd_merge: the combinational per-byte newest-match priority merge across entries, producing mask, data and hit.

## Test plan
- Reset, then read addr 0x05 holding 0x1122334455667788: RD_RVALID at t+1 with that data, and WB_EMPTY stays 1.
- Write 0x05 WE=0x0F data 0xAAAAAAAA_BBBBBBBB, then read 0x05 in the next cycle with the buffer not yet drained.
  - FWD_EN defined: RD_RDATA = 0x11223344_BBBBBBBB.
  - FWD_EN undefined: RD_READY = 0 until drained, then the same data.
- Two writes to 0x07, WE=0xFF data 0x1 then WE=0x01 data 0x22, then read 0x07: returns 0x22, newest wins per byte.
- Fill 4 writes while RD_VALID is held high: WR_READY = 0 at count 4, the head drains with RD_READY = 0, and the read completes afterwards.
- Simultaneous WR and RD to 0x09 in the same cycle: the response returns the old RAM data. A subsequent read returns the new data.
- Assert RST_N low with 3 entries buffered and a read in flight: RD_RVALID = 0, WB_EMPTY = 1, and no RAM_WE after release.
